ws2812_decoder: RTL and testbench
=================================

WS2812_DECODER -- requirements
Module: ws2812_decoder

Interface
REQ-001 Param T_ONE_MIN, default 40: minimum high-pulse length in clk cycles that decodes as bit 1; shorter decodes as 0.
REQ-002 Param T_HIGH_MAX, default 80: a high pulse longer than this many cycles is a protocol error.
REQ-003 Param T_LATCH, default 3000: continuous low cycles that end a frame (latch gap).
REQ-004 Param N_PIX, default 16: pixels accepted per frame.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 din  in  1  asynchronous WS2812 serial line.
REQ-008 pix_data  out  24  last decoded word, GRB order, MSB first on wire.
REQ-009 pix_valid  out  1  one-cycle strobe; pix_data and pix_idx valid while high.
REQ-010 pix_idx  out  4  index 0..N_PIX-1 of pixel in pix_data.
REQ-011 frame_done  out  1  one-cycle strobe on latch gap.
REQ-012 pix_count  out  5  pixels completed in the frame just ended; valid with frame_done.
REQ-013 err  out  1  one-cycle strobe on protocol error.
REQ-014 overflow  out  1  sticky: more than N_PIX words in current frame; cleared at frame_done.

Function
REQ-015 din SHALL pass a 2-flop synchronizer; all decoding uses the synchronized signal only.
REQ-016 States SHALL be: WAIT_GAP, IDLE, HIGH, LOW, ERROR.
REQ-017 WAIT_GAP: count low cycles, restart on high; after T_LATCH low -> IDLE, no frame_done.
REQ-018 IDLE/LOW: rising edge -> HIGH, high counter cleared to 1.
REQ-019 HIGH: count cycles; falling edge -> LOW, decode bit = (count >= T_ONE_MIN), shift into 24-bit register MSB first.
REQ-020 HIGH: count exceeding T_HIGH_MAX -> ERROR, err pulses once, partial word and bit count discarded.
REQ-021 ERROR: wait for falling edge, then behave as WAIT_GAP (requires full T_LATCH low before decoding).
REQ-022 24th bit: pix_valid pulses exactly 3 clk cycles after the first clk edge sampling din=0 at the pin; bit counter returns to 0.
REQ-023 pix_valid SHALL assert only while pix_idx < N_PIX; surplus words set overflow and produce no strobe.
REQ-024 pix_idx increments after each strobe; never wraps within a frame.
REQ-025 LOW: low counter reaching T_LATCH -> IDLE, frame_done pulses once, pix_count = words completed (saturate at N_PIX), pix_idx/bit counter/shift register cleared, overflow cleared.
REQ-026 Partial word (1-23 bits) at latch gap SHALL be discarded silently; not counted, no err.
REQ-027 Low and high counters SHALL saturate; width sufficient for T_LATCH.
REQ-028 pix_data SHALL hold its value between strobes.
REQ-029 pix_valid and frame_done SHALL never assert in the same cycle (latch gap ≥ T_LATCH after final bit).

Reset
REQ-030 On rst: state WAIT_GAP, synchronizer to 0, all counters 0, pix_data 0, pix_idx 0, pix_count 0, all strobes 0, overflow 0.
REQ-031 rst asserted mid-word or mid-frame SHALL abort; no strobe emitted on or after reset cycle until new frame.

Verification (bench params T_ONE_MIN=10, T_HIGH_MAX=20, T_LATCH=100, N_PIX=16)
REQ-032 120 low, then 24 bits of 0xA5C3F0 (1=15hi/10lo, 0=5hi/20lo) -> one pix_valid, pix_data=0xA5C3F0, pix_idx=0, 3 cycles after final fall; 100 low -> frame_done, pix_count=1.
REQ-033 120 low, 18 words -> 16 strobes idx 0..15, overflow=1 after word 17; latch -> pix_count=16, overflow=0.
REQ-034 High pulse of 25 cycles mid-word -> err one cycle, no pix_valid; next valid word only decoded after ≥100 low.
REQ-035 12 bits then 100 low -> frame_done, pix_count=0, no pix_valid, no err.
REQ-036 Boundary: high of exactly 10 -> bit 1, 9 -> bit 0; low of 99 -> no frame_done, 100 -> frame_done.
REQ-037 rst pulsed after bit 20 of a word -> all outputs 0; traffic without 100-low gap -> no strobes.

Source files
------------

// File: rtl/ws2812_decoder.sv
// WS2812 serial line decoder: recovers 24-bit GRB pixel words from pulse widths
// and reports pixel strobes, frame latch gaps and protocol errors.
module ws2812_decoder #(
    parameter int T_ONE_MIN  = 40,
    parameter int T_HIGH_MAX = 80,
    parameter int T_LATCH    = 3000,
    parameter int N_PIX      = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        din,
    output logic [23:0] pix_data,
    output logic        pix_valid,
    output logic [3:0]  pix_idx,
    output logic        frame_done,
    output logic [4:0]  pix_count,
    output logic        err,
    output logic        overflow
);

    localparam int CW = $clog2(T_LATCH + 1);
    localparam logic [CW-1:0] LATCH_C = CW'(T_LATCH);
    localparam logic [CW-1:0] ONE_C   = CW'(T_ONE_MIN);
    localparam logic [CW-1:0] HMAX_C  = CW'(T_HIGH_MAX);
    localparam logic [4:0]    NPIX_C  = 5'(N_PIX);

    typedef enum logic [2:0] {WAIT_GAP, IDLE, HIGH, LOW, ERROR} state_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
        return (&c) ? c : c + CW'(1);
    endfunction

    state_t         state, state_nxt;
    logic           din_p0, din_p1;
    logic [CW-1:0]  hi_cnt, lo_cnt, lo_inc;
    logic [4:0]     bit_cnt, word_cnt;
    logic [23:0]    shift, shift_nxt;
    logic           word_vld_p2;
    logic [23:0]    word_p2;
    logic [3:0]     idx_p2;
    logic           gap_done, frame_end, bit_done, hi_err;

    assign lo_inc    = sat_inc(lo_cnt);
    assign shift_nxt = {shift[22:0], (hi_cnt >= ONE_C)};

    // Stage p0/p1: two-flop synchronizer, everything below sees din_p1 only
    always_ff @(posedge clk) begin
        if (rst) begin
            din_p0 <= 1'b0;
            din_p1 <= 1'b0;
        end else begin
            din_p0 <= din;
            din_p1 <= din_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_GAP;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            WAIT_GAP: if (gap_done) state_nxt = IDLE;
            IDLE:     if (din_p1) state_nxt = HIGH;
            HIGH:     if (hi_err) state_nxt = ERROR;
                      else if (bit_done) state_nxt = LOW;
            LOW:      if (din_p1) state_nxt = HIGH;
                      else if (frame_end) state_nxt = IDLE;
            ERROR:    if (!din_p1) state_nxt = WAIT_GAP;
            default:  state_nxt = WAIT_GAP;
        endcase
    end

    always_comb begin
        gap_done  = 1'b0;
        frame_end = 1'b0;
        bit_done  = 1'b0;
        hi_err    = 1'b0;
        unique case (state)
            WAIT_GAP: gap_done  = !din_p1 && (lo_inc >= LATCH_C);
            HIGH:     begin
                          hi_err   = din_p1 && (hi_cnt >= HMAX_C);
                          bit_done = !din_p1;
                      end
            LOW:      frame_end = !din_p1 && (lo_inc >= LATCH_C);
            default:  ;
        endcase
    end

    // Stage p2: word assembly and pulse-width counting; stage p3 drives the outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            hi_cnt      <= '0;
            lo_cnt      <= '0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            shift       <= '0;
            word_vld_p2 <= 1'b0;
            word_p2     <= '0;
            idx_p2      <= '0;
            pix_valid   <= 1'b0;
            pix_data    <= '0;
            pix_idx     <= '0;
            frame_done  <= 1'b0;
            pix_count   <= '0;
            err         <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            word_vld_p2 <= 1'b0;
            frame_done  <= 1'b0;
            err         <= hi_err;
            pix_valid   <= word_vld_p2;
            if (word_vld_p2) begin
                pix_data <= word_p2;
                pix_idx  <= idx_p2;
            end

            unique case (state)
                WAIT_GAP: lo_cnt <= din_p1 ? '0 : lo_inc;
                IDLE, LOW: if (din_p1) hi_cnt <= CW'(1);
                           else        lo_cnt <= lo_inc;
                HIGH:     if (din_p1) hi_cnt <= sat_inc(hi_cnt);
                          else        lo_cnt <= CW'(1);
                ERROR:    lo_cnt <= din_p1 ? '0 : CW'(1);
                default:  ;
            endcase

            if (bit_done) begin
                if (bit_cnt == 5'd23) begin
                    bit_cnt <= '0;
                    shift   <= '0;
                    if (word_cnt < NPIX_C) begin
                        word_vld_p2 <= 1'b1;
                        word_p2     <= shift_nxt;
                        idx_p2      <= 4'(word_cnt);
                        word_cnt    <= word_cnt + 5'd1;
                    end else begin
                        overflow <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 5'd1;
                    shift   <= shift_nxt;
                end
            end

            if (hi_err) begin
                bit_cnt <= '0;
                shift   <= '0;
            end

            // A gap after an error starts a fresh frame without announcing one
            if (gap_done || frame_end) begin
                word_cnt <= '0;
                bit_cnt  <= '0;
                shift    <= '0;
                overflow <= 1'b0;
            end

            if (frame_end) begin
                frame_done <= 1'b1;
                pix_count  <= word_cnt;
                pix_idx    <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ws2812_decoder.sv
// Directed bench for ws2812_decoder with T_ONE_MIN=10, T_HIGH_MAX=20,
// T_LATCH=100, N_PIX=16.
module tb_ws2812_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din = 1'b0;
    logic [23:0] pix_data;
    logic        pix_valid;
    logic [3:0]  pix_idx;
    logic        frame_done;
    logic [4:0]  pix_count;
    logic        err;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    int          pv_cnt = 0, fd_cnt = 0, err_cnt = 0, both_cnt = 0;
    logic [4:0]  last_pc = '0;
    logic [23:0] rec_data [32];
    logic [3:0]  rec_idx  [32];

    ws2812_decoder #(
        .T_ONE_MIN (10),
        .T_HIGH_MAX(20),
        .T_LATCH   (100),
        .N_PIX     (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_idx   (pix_idx),
        .frame_done(frame_done),
        .pix_count (pix_count),
        .err       (err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Event recorder sampled away from the active edge
    always @(negedge clk) begin
        if (pix_valid) begin
            if (pv_cnt < 32) begin
                rec_data[pv_cnt] = pix_data;
                rec_idx[pv_cnt]  = pix_idx;
            end
            pv_cnt++;
        end
        if (frame_done) begin
            fd_cnt++;
            last_pc = pix_count;
        end
        if (err) err_cnt++;
        if (pix_valid && frame_done) both_cnt++;
    end

    task automatic hold(input int n, input logic v);
        din = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        hold(b ? 15 : 5, 1'b1);
        hold(b ? 10 : 20, 1'b0);
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i]);
    endtask

    function automatic logic [23:0] ovf_word(input int k);
        return {8'(k), 8'(8'hF0 ^ k), 8'(k * 3)};
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        hold(3, 1'b0);
        checks++;
        if ({pix_data, pix_valid, pix_idx, frame_done, pix_count, err, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got data=%h v=%b idx=%0d fd=%b pc=%0d err=%b ovf=%b, want all 0",
                     pix_data, pix_valid, pix_idx, frame_done, pix_count, err, overflow);
        end
        rst = 1'b0;
        hold(1, 1'b0);
    endtask

    task automatic test_single_word;
        logic [23:0] w;
        int pv0, fd0;
        w = 24'hA5C3F0;
        hold(120, 1'b0);
        pv0 = pv_cnt;
        fd0 = fd_cnt;
        for (int i = 23; i >= 1; i--) send_bit(w[i]);
        hold(5, 1'b1);
        din = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            checks++;
            if (pix_valid !== (k == 4)) begin
                errors++;
                $display("FAIL single_latency: edge %0d after fall pix_valid=%b want %b", k, pix_valid, k == 4);
            end
            if (k == 4) begin
                checks++;
                if (pix_data !== w || pix_idx !== 4'd0) begin
                    errors++;
                    $display("FAIL single_data: got %h idx %0d want %h idx 0", pix_data, pix_idx, w);
                end
            end
        end
        hold(95, 1'b0);
        hold(5, 1'b0);
        checks++;
        if (fd_cnt - fd0 !== 1 || last_pc !== 5'd1) begin
            errors++;
            $display("FAIL single_frame: frame_done count %0d pix_count %0d want 1 and 1", fd_cnt - fd0, last_pc);
        end
        checks++;
        if (pv_cnt - pv0 !== 1) begin
            errors++;
            $display("FAIL single_strobes: got %0d want 1", pv_cnt - pv0);
        end
        hold(30, 1'b0);
        checks++;
        if (pix_data !== w) begin
            errors++;
            $display("FAIL hold_data: got %h want %h", pix_data, w);
        end
    endtask

    task automatic test_overflow;
        int pv0, fd0;
        logic bad;
        hold(120, 1'b0);
        pv0 = pv_cnt;
        fd0 = fd_cnt;
        for (int k = 0; k < 18; k++) begin
            send_word(ovf_word(k));
            if (k == 15 || k == 16) begin
                checks++;
                if (overflow !== (k == 16)) begin
                    errors++;
                    $display("FAIL overflow_flag: after word %0d got %b want %b", k + 1, overflow, k == 16);
                end
            end
        end
        checks++;
        if (pv_cnt - pv0 !== 16) begin
            errors++;
            $display("FAIL overflow_strobes: got %0d want 16", pv_cnt - pv0);
        end
        bad = 1'b0;
        for (int k = 0; k < 16; k++)
            if (pv0 + k < 32 && (rec_idx[pv0 + k] !== 4'(k) || rec_data[pv0 + k] !== ovf_word(k))) bad = 1'b1;
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL overflow_sequence: idx/data of strobes 0..15 not as sent (first idx %0d data %h)",
                     rec_idx[pv0], rec_data[pv0]);
        end
        hold(110, 1'b0);
        checks++;
        if (fd_cnt - fd0 !== 1 || last_pc !== 5'd16 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL overflow_latch: fd %0d pix_count %0d overflow %b want 1, 16, 0", fd_cnt - fd0, last_pc, overflow);
        end
    endtask

    task automatic test_error;
        int pv0, er0;
        logic [23:0] w;
        w = 24'h3C5A96;
        hold(120, 1'b0);
        pv0 = pv_cnt;
        er0 = err_cnt;
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        hold(25, 1'b1);
        hold(10, 1'b0);
        checks++;
        if (err_cnt - er0 !== 1) begin
            errors++;
            $display("FAIL error_pulse: err high for %0d cycles want 1", err_cnt - er0);
        end
        send_word(w);
        checks++;
        if (pv_cnt !== pv0) begin
            errors++;
            $display("FAIL error_no_decode: got %0d strobes want 0", pv_cnt - pv0);
        end
        hold(120, 1'b0);
        send_word(w);
        checks++;
        if (pv_cnt - pv0 !== 1 || pix_data !== w) begin
            errors++;
            $display("FAIL error_recover: strobes %0d data %h want 1 and %h", pv_cnt - pv0, pix_data, w);
        end
        hold(110, 1'b0);
    endtask

    task automatic test_partial;
        int pv0, fd0, er0;
        hold(120, 1'b0);
        pv0 = pv_cnt;
        fd0 = fd_cnt;
        er0 = err_cnt;
        for (int i = 0; i < 12; i++) send_bit(i[1]);
        hold(105, 1'b0);
        checks++;
        if (fd_cnt - fd0 !== 1 || last_pc !== 5'd0 || pv_cnt !== pv0 || err_cnt !== er0) begin
            errors++;
            $display("FAIL partial_word: fd %0d pc %0d strobes %0d err %0d want 1, 0, 0, 0",
                     fd_cnt - fd0, last_pc, pv_cnt - pv0, err_cnt - er0);
        end
    endtask

    task automatic test_boundary;
        int pv0, fd0;
        hold(120, 1'b0);
        pv0 = pv_cnt;
        hold(10, 1'b1);
        hold(15, 1'b0);
        hold(9, 1'b1);
        hold(15, 1'b0);
        send_word(24'h2AAAAA << 2);
        checks++;
        if (pv_cnt - pv0 !== 1 || pix_data !== 24'hAAAAAA) begin
            errors++;
            $display("FAIL width_boundary: strobes %0d data %h want 1 and aaaaaa", pv_cnt - pv0, pix_data);
        end
        hold(110, 1'b0);
        fd0 = fd_cnt;
        hold(15, 1'b1);
        hold(99, 1'b0);
        hold(15, 1'b1);
        checks++;
        if (fd_cnt !== fd0) begin
            errors++;
            $display("FAIL gap_99: got %0d frame_done want 0", fd_cnt - fd0);
        end
        hold(100, 1'b0);
        hold(5, 1'b0);
        checks++;
        if (fd_cnt - fd0 !== 1 || last_pc !== 5'd0) begin
            errors++;
            $display("FAIL gap_100: frame_done %0d pc %0d want 1 and 0", fd_cnt - fd0, last_pc);
        end
    endtask

    task automatic test_reset_midword;
        int pv0;
        hold(120, 1'b0);
        for (int i = 0; i < 20; i++) send_bit(1'b1);
        rst = 1'b1;
        hold(2, 1'b0);
        checks++;
        if ({pix_data, pix_valid, pix_idx, frame_done, pix_count, err, overflow} !== '0) begin
            errors++;
            $display("FAIL reset_midword: got data=%h v=%b idx=%0d pc=%0d ovf=%b want all 0",
                     pix_data, pix_valid, pix_idx, pix_count, overflow);
        end
        rst = 1'b0;
        pv0 = pv_cnt;
        for (int i = 0; i < 4; i++) send_bit(1'b0);
        send_word(24'h123456);
        send_word(24'hFEDCBA);
        checks++;
        if (pv_cnt !== pv0 || pix_data !== 24'h0) begin
            errors++;
            $display("FAIL reset_no_gap: strobes %0d data %h want 0 and 000000", pv_cnt - pv0, pix_data);
        end
    endtask

    initial begin
        test_reset;
        test_single_word;
        test_overflow;
        test_error;
        test_partial;
        test_boundary;
        test_reset_midword;
        checks++;
        if (both_cnt !== 0) begin
            errors++;
            $display("FAIL strobe_overlap: pix_valid with frame_done %0d times want 0", both_cnt);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
